hidden_layer_mac: RTL

HIDDEN_LAYER_MAC -- requirements
Module: hidden_layer_mac

---
 rtl/nn_pkg.sv | 17 +
 rtl/nn_mac_unit.sv | 24 ++
 rtl/hidden_layer_mac.sv | 104 ++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared types, widths and output clamp for the hidden-layer MAC.
// Exports state_t (IDLE/MAC/BIAS/DONE), DATA_W=8, ACC_W=24 and clamp8().
// Macro HIDDEN_LAYER_RELU_EN: clamp to [0,127] instead of signed [-128,127].
package nn_pkg;
   localparam int DATA_W = 8;
   localparam int ACC_W  = 24;
   typedef enum logic [1:0] {S_IDLE, S_MAC, S_BIAS, S_DONE} state_t;
   localparam logic signed [ACC_W-1:0] MAX_V = 127;
   localparam logic signed [ACC_W-1:0] MIN_V = -128;
   function automatic logic [DATA_W-1:0] clamp8(input logic signed [ACC_W-1:0] v);
`ifdef HIDDEN_LAYER_RELU_EN
      return (v < 0) ? 8'h00 : ((v > MAX_V) ? 8'h7F : v[DATA_W-1:0]);
`else
      return (v > MAX_V) ? 8'h7F : ((v < MIN_V) ? 8'h80 : v[DATA_W-1:0]);
`endif
   endfunction
endpackage

// File: rtl/nn_mac_unit.sv
// nn_mac_unit: signed 8x8 multiply into a 24-bit accumulator with clear.
// Ports: clk, rst_n (async active-low), i_clr (clear, wins over i_en),
// i_en (accumulate i_a*i_b), i_a/i_b signed bytes, o_acc accumulator.
module nn_mac_unit
   import nn_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [ACC_W-1:0]  o_acc
);
   logic signed [2*DATA_W-1:0] w_prod;
   logic [ACC_W-1:0]           r_acc;
   assign w_prod = $signed(i_a) * $signed(i_b);
   assign o_acc  = r_acc;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_acc <= '0;
      else if (i_clr) r_acc <= '0;
      else if (i_en) r_acc <= r_acc + ACC_W'(w_prod);
   end
endmodule

// File: rtl/hidden_layer_mac.sv
// hidden_layer_mac: one fully-connected layer, one MAC per cycle, N_OUT
// neurons of N_IN inputs each, result bytes presented with valid/ready.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data input
// vector; weight/bias static configuration; out_valid/out_ready/out_data.
// Macro HIDDEN_LAYER_RELU_EN selects ReLU clamp (see nn_pkg::clamp8).
module hidden_layer_mac
   import nn_pkg::*;
#(
   parameter int N_IN       = 62,
   parameter int N_OUT      = 10,
   parameter int FRAC_SHIFT = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [8*N_IN-1:0]         in_data,
   input  logic [8*N_IN*N_OUT-1:0]   weight,
   input  logic [8*N_OUT-1:0]        bias,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [8*N_OUT-1:0]        out_data
);
   localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   state_t                   r_state;
   logic [IW-1:0]            r_i;
   logic [JW-1:0]            r_j;
   logic [8*N_IN-1:0]        r_x;
   logic [8*N_OUT-1:0]       r_out;
   logic                     r_in_ready;
   logic                     r_out_valid;
   logic                     w_accept;
   logic [31:0]              w_widx;
   logic [DATA_W-1:0]        w_a;
   logic [DATA_W-1:0]        w_w;
   logic [DATA_W-1:0]        w_bias;
   logic [ACC_W-1:0]         w_acc;
   logic signed [ACC_W-1:0]  w_sum;
   logic signed [ACC_W-1:0]  w_r;
   logic [DATA_W-1:0]        w_byte;
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out;
   assign w_accept  = in_valid && r_in_ready;
   assign w_widx    = 32'(r_j) * N_IN + 32'(r_i);
   assign w_a       = r_x[8*r_i +: 8];
   assign w_w       = weight[8*w_widx +: 8];
   assign w_bias    = bias[8*r_j +: 8];
   assign w_sum     = $signed(w_acc) + ACC_W'($signed(w_bias));
   // Left-then-right shift in ACC_W bits: drops bits that overflow the accumulator width.
   assign w_r       = (w_sum <<< FRAC_SHIFT) >>> FRAC_SHIFT;
   assign w_byte    = clamp8(w_r);
   nn_mac_unit u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_accept || r_state == S_BIAS),
      .i_en  (r_state == S_MAC),
      .i_a   (w_a),
      .i_b   (w_w),
      .o_acc (w_acc)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_i         <= '0;
         r_j         <= '0;
         r_x         <= '0;
         r_out       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_x        <= in_data;
               r_i        <= '0;
               r_j        <= '0;
               r_in_ready <= 1'b0;
               r_state    <= S_MAC;
            end
            S_MAC: if (r_i == IW'(N_IN - 1)) begin
               r_i     <= '0;
               r_state <= S_BIAS;
            end else r_i <= r_i + 1'b1;
            S_BIAS: begin
               r_out[8*r_j +: 8] <= w_byte;
               if (r_j == JW'(N_OUT - 1)) begin
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_j     <= r_j + 1'b1;
                  r_state <= S_MAC;
               end
            end
            S_DONE: if (out_ready) begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
